// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: parallel operands in, LSB-first add, parallel sum out.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf_o.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
    logic             carry, carry_next, bit_s;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid_i)  state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
    end

    // Full-adder cell; the new sum bit enters at the MSB so WIDTH shifts leave it LSB-aligned.
    always_comb begin
        bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        sum_next   = sum_sh >> 1;
        sum_next[WIDTH-1] = bit_s;
    end

    assign accept = in_valid_i & in_ready_o;
    assign last   = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_o  <= '0;
            cout_o <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_o  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a_i;
            b_sh   <= b_i;
            sum_sh <= '0;
            carry  <= cin_i;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_next;
            carry  <= carry_next;
            cnt    <= cnt + CW'(1);
            // Outputs update only on the final bit so they hold steady outside DONE.
            if (last) begin
                sum_o  <= sum_next;
                cout_o <= carry_next;
`ifdef SERIAL_ADD_OVF_EN
                ovf_o  <= carry ^ carry_next;
`endif
            end
        end
    end

endmodule
